// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-period helper.
// Shared by the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uartState_t;

  // Clock cycles per serial bit, truncating integer division.
  function automatic int unsigned symbolEdgeTime(input int unsigned clockFreq,
                                                 input int unsigned baudRate);
    return clockFreq / baudRate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: pulses Tick_c on the last cycle of every bit period.
// Clear holds the counter at zero so a new frame starts on a bit boundary.
module uart_baud_tick #(
  parameter int unsigned SYMBOL_EDGE_TIME = 10
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Clear,
  output logic Tick_c
);

  localparam int unsigned CW = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;

  logic [CW-1:0] count;

  assign Tick_c = (count == CW'(SYMBOL_EDGE_TIME - 1));

  // Restart at each bit boundary, so the counter never wraps inside a bit.
  always_ff @(posedge Clock) begin
    if (Reset || Clear || Tick_c) count <= '0;
    else                          count <= count + CW'(1);
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with valid/ready byte input and registered serial output.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [DATA_BITS-1:0] DataIn,
  input  logic                 DataInValid,
  output logic                 DataInReady,
  output logic                 SOut
);

  localparam int unsigned SYMBOL_EDGE_TIME = symbolEdgeTime(CLOCK_FREQ, BAUD_RATE);

  uartState_t           state, stateNext;
  logic [2:0]           bitIdx, bitIdxNext;
  logic [DATA_BITS-1:0] dataReg;
  logic                 sOutNext, readyNext;
  logic                 accept;
  logic                 tick;

  assign accept = (state == IDLE) && DataInValid && DataInReady;

  uart_baud_tick #(
    .SYMBOL_EDGE_TIME(SYMBOL_EDGE_TIME)
  ) baudTick (
    .Clock (Clock),
    .Reset (Reset),
    .Clear (state == IDLE),
    .Tick_c(tick)
  );

  // State and datapath registers; outputs are registered from next-state values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      bitIdx      <= 3'd0;
      dataReg     <= '0;
      SOut        <= 1'b1;
      DataInReady <= 1'b1;
    end else begin
      state       <= stateNext;
      bitIdx      <= bitIdxNext;
      SOut        <= sOutNext;
      DataInReady <= readyNext;
      if (accept) dataReg <= DataIn;
    end
  end

  // Next-state and bit index.
  always_comb begin
    stateNext  = state;
    bitIdxNext = bitIdx;
    case (state)
      IDLE: begin
        bitIdxNext = 3'd0;
        if (accept) stateNext = START;
      end
      START: if (tick) stateNext = DATA;
      DATA: begin
        if (tick) begin
          bitIdxNext = 3'(bitIdx + 3'd1);
          if (bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            stateNext = PARITY;
`else
            stateNext = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) stateNext = STOP;
`endif
      STOP: if (tick) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output values for the state being entered.
  always_comb begin
    sOutNext  = 1'b1;
    readyNext = 1'b0;
    case (stateNext)
      IDLE:  readyNext = 1'b1;
      START: sOutNext  = 1'b0;
      DATA:  sOutNext  = dataReg[bitIdxNext];
`ifdef UART_TX_PARITY_EN
      PARITY: sOutNext = ^dataReg;
`endif
      default: sOutNext = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter at 10 clocks per bit.
// Build with UART_TX_PARITY_EN defined to check the parity frame format.
module tb_uart_transmitter;

  localparam int unsigned CLOCK_FREQ = 1000;
  localparam int unsigned BAUD_RATE  = 100;
  localparam int          SET        = 10;
`ifdef UART_TX_PARITY_EN
  localparam int          FRAME_BITS = 11;
`else
  localparam int          FRAME_BITS = 10;
`endif
  localparam int          FRAME_CYC  = SET * FRAME_BITS;

  logic       Clock;
  logic       Reset;
  logic [7:0] DataIn;
  logic       DataInValid;
  logic       DataInReady;
  logic       SOut;

  int         vectors     = 0;
  int         miscompares = 0;
  int         pushedCount = 0;
  int         framesSeen  = 0;
  logic [7:0] sbQ[$];

  uart_transmitter #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .DataIn     (DataIn),
    .DataInValid(DataInValid),
    .DataInReady(DataInReady),
    .SOut       (SOut)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level during bit k of a frame carrying b.
  function automatic logic frameBit(input logic [7:0] b, input int k);
    logic [10:0] f;
`ifdef UART_TX_PARITY_EN
    f = {1'b1, ^b, b, 1'b0};
`else
    f = {2'b11, b, 1'b0};
`endif
    return f[k];
  endfunction

  // Called at a negedge; returns just after the accept edge.
  task automatic sendByte(input logic [7:0] b, input bit pushIt);
    int n = 0;
    while (DataInReady !== 1'b1 && n < 500) begin
      @(negedge Clock);
      n++;
    end
    chk("ready_wait", 32'(DataInReady), 32'd1);
    DataIn      = b;
    DataInValid = 1'b1;
    if (pushIt) begin
      sbQ.push_back(b);
      pushedCount++;
    end
    @(posedge Clock);
  endtask

  // Per-cycle check of n frame cycles after an accept edge.
  task automatic expectFrame(input logic [7:0] b, input int n,
                             input logic nextValid, input logic [7:0] nextData);
    for (int c = 0; c < n; c++) begin
      @(negedge Clock);
      if (c == 0) begin
        DataInValid = nextValid;
        DataIn      = nextData;
      end
      chk($sformatf("sout_%02h_c%0d", b, c), 32'(SOut), 32'(frameBit(b, c / SET)));
      chk($sformatf("ready_%02h_c%0d", b, c), 32'(DataInReady), 32'd0);
    end
  endtask

  // Frame decoder: samples mid-bit, pops the scoreboard on each complete frame.
  initial begin : monitor
    logic       rx[0:10];
    logic [7:0] rxByte;
    logic [7:0] expByte;
    bit         aborted;
    forever begin
      @(negedge Clock);
      if (SOut === 1'b0) begin
        aborted = 1'b0;
        for (int c = 1; c < FRAME_CYC; c++) begin
          @(posedge Clock);
          if (Reset) aborted = 1'b1;
          @(negedge Clock);
          if (c % SET == SET / 2) rx[c / SET] = SOut;
        end
        if (!aborted) begin
          framesSeen++;
          for (int i = 0; i < 8; i++) rxByte[i] = rx[i + 1];
          if (sbQ.size() == 0) begin
            chk("unexpected_frame", 32'(rxByte), 32'hFFFF_FFFF);
          end else begin
            expByte = sbQ.pop_front();
            chk("rx_start", 32'(rx[0]), 32'd0);
            chk("rx_byte", 32'(rxByte), 32'(expByte));
`ifdef UART_TX_PARITY_EN
            chk("rx_parity", 32'(rx[9]), 32'(^expByte));
`endif
            chk("rx_stop", 32'(rx[FRAME_BITS - 1]), 32'd1);
          end
        end
      end
    end
  end

  initial begin
    Reset       = 1'b1;
    DataInValid = 1'b1;
    DataIn      = 8'h3C;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("rst_sout", 32'(SOut), 32'd1);
    chk("rst_ready", 32'(DataInReady), 32'd1);
    Reset       = 1'b0;
    DataInValid = 1'b0;

    // Idle: no stimulus for 200 cycles.
    for (int c = 0; c < 200; c++) begin
      @(negedge Clock);
      chk("idle_sout", 32'(SOut), 32'd1);
      chk("idle_ready", 32'(DataInReady), 32'd1);
    end

    // Single frame; DataIn changes mid-frame.
    sendByte(8'h7A, 1'b1);
    expectFrame(8'h7A, FRAME_CYC, 1'b0, 8'h85);
    @(negedge Clock);
    chk("post_7a_ready", 32'(DataInReady), 32'd1);
    chk("post_7a_sout", 32'(SOut), 32'd1);

    // Back-to-back with DataInValid held high.
    sendByte(8'h55, 1'b1);
    expectFrame(8'h55, FRAME_CYC, 1'b1, 8'hAA);
    @(negedge Clock);
    chk("b2b_gap_ready", 32'(DataInReady), 32'd1);
    chk("b2b_gap_sout", 32'(SOut), 32'd1);
    sbQ.push_back(8'hAA);
    pushedCount++;
    @(posedge Clock);
    expectFrame(8'hAA, FRAME_CYC, 1'b0, 8'h00);
    @(negedge Clock);
    chk("post_aa_ready", 32'(DataInReady), 32'd1);

    // Reset at cycle 35 of a frame, with DataInValid high during reset.
    sendByte(8'h7A, 1'b0);
    expectFrame(8'h7A, 35, 1'b0, 8'h7A);
    Reset       = 1'b1;
    DataInValid = 1'b1;
    DataIn      = 8'hC3;
    @(negedge Clock);
    Reset       = 1'b0;
    DataInValid = 1'b0;
    chk("abort_sout", 32'(SOut), 32'd1);
    chk("abort_ready", 32'(DataInReady), 32'd1);
    for (int c = 0; c < 120; c++) begin
      @(negedge Clock);
      chk("abort_idle_sout", 32'(SOut), 32'd1);
      chk("abort_idle_ready", 32'(DataInReady), 32'd1);
    end

    // Loopback-style decode of all-zero and all-one bytes.
    sendByte(8'h00, 1'b1);
    expectFrame(8'h00, FRAME_CYC, 1'b0, 8'h00);
    @(negedge Clock);
    sendByte(8'hFF, 1'b1);
    expectFrame(8'hFF, FRAME_CYC, 1'b0, 8'h00);

    repeat (30) @(negedge Clock);
    chk("sb_empty", 32'(sbQ.size()), 32'd0);
    chk("frames_seen", 32'(framesSeen), 32'(pushedCount));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
